// File: rtl/calc_scheduler.sv
// Round-robin front end that shares one combinational calculator between two requesters,
// holds operands for a settle window, then returns the captured result on a valid/ready channel.
module calc_scheduler #(
  parameter int DW     = 4,
  parameter int OPW    = 3,
  parameter int RW     = 8,
  parameter int SETTLE = 1,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [OPW-1:0]  req0_optr,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [OPW-1:0]  req1_optr,
  output logic [DW-1:0]   calc_a,
  output logic [DW-1:0]   calc_b,
  output logic [OPW-1:0]  calc_optr,
  input  logic [RW-1:0]   calc_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [RW-1:0]   rsp_data,
  output logic            rsp_sign,
  output logic            rsp_id,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Subtraction op with a < b: the datapath reports magnitude only, so the sign travels separately.
  function automatic logic calc_sign(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input logic [OPW-1:0] optr);
    return (optr == OPW'(1)) && (a < b);
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_grant_q, last_grant_d;
  logic [DW-1:0]   calc_a_q, calc_a_d, calc_b_q, calc_b_d;
  logic [OPW-1:0]  calc_optr_q, calc_optr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [RW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_sign_q, rsp_sign_d;
  logic            rsp_id_q, rsp_id_d;
  logic            busy_q, busy_d;
  logic [CNTW-1:0] op_count_q, op_count_d;
  logic            grant_s;
  logic            any_req_s;

  // Round-robin pick: on contention the requester not served last time wins.
  always_comb begin
    any_req_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (req0_valid) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
    req0_ready = (state_q == IDLE) && req0_valid && !grant_s;
    req1_ready = (state_q == IDLE) && req1_valid && grant_s;
  end

  // Next-state and datapath register updates; everything holds unless a transition fires.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    calc_a_d     = calc_a_q;
    calc_b_d     = calc_b_q;
    calc_optr_d  = calc_optr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_sign_d   = rsp_sign_q;
    rsp_id_d     = rsp_id_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          calc_a_d     = grant_s ? req1_a : req0_a;
          calc_b_d     = grant_s ? req1_b : req0_b;
          calc_optr_d  = grant_s ? req1_optr : req0_optr;
          rsp_sign_d   = calc_sign(calc_a_d, calc_b_d, calc_optr_d);
          rsp_id_d     = grant_s;
          last_grant_d = grant_s;
          cnt_d        = CW'(SETTLE - 1);
          state_d      = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == CW'(0)) begin
          rsp_data_d  = calc_result;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNTW'(1);
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= CW'(0);
      last_grant_q <= 1'b1;
      calc_a_q     <= DW'(0);
      calc_b_q     <= DW'(0);
      calc_optr_q  <= OPW'(0);
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= RW'(0);
      rsp_sign_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
      busy_q       <= 1'b0;
      op_count_q   <= CNTW'(0);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      calc_a_q     <= calc_a_d;
      calc_b_q     <= calc_b_d;
      calc_optr_q  <= calc_optr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_sign_q   <= rsp_sign_d;
      rsp_id_q     <= rsp_id_d;
      busy_q       <= busy_d;
      op_count_q   <= op_count_d;
    end
  end

  assign calc_a    = calc_a_q;
  assign calc_b    = calc_b_q;
  assign calc_optr = calc_optr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_sign  = rsp_sign_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_calc_scheduler.sv
// Directed bench for calc_scheduler: default build (SETTLE=1) plus a SETTLE=3/CNTW=2 build,
// each driving a stub calculator result = {a,b} + optr.
module tb_calc_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       r0_v, r1_v, r0_rdy, r1_rdy;
  logic [3:0] r0_a, r0_b, r1_a, r1_b, c_a, c_b;
  logic [2:0] r0_op, r1_op, c_op;
  logic [7:0] c_res, rsp_d;
  logic       rsp_v, rsp_rdy, rsp_s, rsp_i, busy;
  logic [15:0] opc;

  logic       v2, rdy2, rdy2_1, rsp2_v, rsp2_rdy, rsp2_s, rsp2_i, busy2;
  logic [3:0] a2, b2, c2_a, c2_b;
  logic [2:0] op2, c2_op;
  logic [7:0] c2_res, rsp2_d;
  logic [1:0] opc2;

  assign c_res  = 8'({c_a, c_b}) + 8'(c_op);
  assign c2_res = 8'({c2_a, c2_b}) + 8'(c2_op);

  calc_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0_v), .req0_ready(r0_rdy), .req0_a(r0_a), .req0_b(r0_b), .req0_optr(r0_op),
    .req1_valid(r1_v), .req1_ready(r1_rdy), .req1_a(r1_a), .req1_b(r1_b), .req1_optr(r1_op),
    .calc_a(c_a), .calc_b(c_b), .calc_optr(c_op), .calc_result(c_res),
    .rsp_valid(rsp_v), .rsp_ready(rsp_rdy), .rsp_data(rsp_d), .rsp_sign(rsp_s), .rsp_id(rsp_i),
    .busy(busy), .op_count(opc)
  );

  calc_scheduler #(.SETTLE(3), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(v2), .req0_ready(rdy2), .req0_a(a2), .req0_b(b2), .req0_optr(op2),
    .req1_valid(1'b0), .req1_ready(rdy2_1), .req1_a(4'd0), .req1_b(4'd0), .req1_optr(3'd0),
    .calc_a(c2_a), .calc_b(c2_b), .calc_optr(c2_op), .calc_result(c2_res),
    .rsp_valid(rsp2_v), .rsp_ready(rsp2_rdy), .rsp_data(rsp2_d), .rsp_sign(rsp2_s), .rsp_id(rsp2_i),
    .busy(busy2), .op_count(opc2)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v0;
    logic [3:0] a0, b0;
    logic [2:0] o0;
    logic       v1;
    logic [3:0] a1, b1;
    logic [2:0] o1;
    logic       id;
    logic [7:0] data;
    logic       sign;
  } vec_t;

  vec_t vecs[8];

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction on the default build: accept, latency, payload, handshake.
  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    r0_v = v.v0; r0_a = v.a0; r0_b = v.b0; r0_op = v.o0;
    r1_v = v.v1; r1_a = v.a1; r1_b = v.b1; r1_op = v.o1;
    rsp_rdy = 1'b0;
    #1;
    chk("ready0", 32'(r0_rdy), 32'(v.v0 && (v.id == 1'b0)));
    chk("ready1", 32'(r1_rdy), 32'(v.v1 && (v.id == 1'b1)));
    @(negedge clk);
    r0_v = 1'b0; r1_v = 1'b0;
    chk("calc_a", 32'(c_a), 32'(v.id ? v.a1 : v.a0));
    chk("busy_exec", 32'(busy), 32'd1);
    lat = 1;
    while (!rsp_v && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd2);
    chk("rsp_data", 32'(rsp_d), 32'(v.data));
    chk("rsp_sign", 32'(rsp_s), 32'(v.sign));
    chk("rsp_id", 32'(rsp_i), 32'(v.id));
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_v), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin : main
    int ids[4];
    int got;
    int lat;
    logic [7:0] held;
    logic [3:0] ea, eb, sa, sb;
    logic [2:0] eo, so;
    logic stable;

    rst = 1'b1; rsp_rdy = 1'b0; rsp2_rdy = 1'b0;
    r0_v = 1'b0; r1_v = 1'b0; r0_a = 4'd0; r0_b = 4'd0; r0_op = 3'd0;
    r1_a = 4'd0; r1_b = 4'd0; r1_op = 3'd0;
    v2 = 1'b0; a2 = 4'd0; b2 = 4'd0; op2 = 3'd0;

    //       v0    a0     b0     o0    v1    a1     b1     o1    id    data    sign
    vecs[0] = '{1'b1, 4'd8,  4'd10, 3'd1, 1'b0, 4'd0,  4'd0,  3'd0, 1'b0, 8'h8B, 1'b1};
    vecs[1] = '{1'b0, 4'd0,  4'd0,  3'd0, 1'b1, 4'd3,  4'd2,  3'd1, 1'b1, 8'h33, 1'b0};
    vecs[2] = '{1'b0, 4'd0,  4'd0,  3'd0, 1'b1, 4'd8,  4'd10, 3'd7, 1'b1, 8'h91, 1'b0};
    vecs[3] = '{1'b1, 4'd1,  4'd2,  3'd1, 1'b1, 4'd5,  4'd5,  3'd0, 1'b0, 8'h13, 1'b1};
    vecs[4] = '{1'b1, 4'd1,  4'd2,  3'd1, 1'b1, 4'd5,  4'd5,  3'd0, 1'b1, 8'h55, 1'b0};
    vecs[5] = '{1'b1, 4'd15, 4'd15, 3'd3, 1'b1, 4'd0,  4'd15, 3'd1, 1'b0, 8'h02, 1'b0};
    vecs[6] = '{1'b1, 4'd15, 4'd15, 3'd3, 1'b1, 4'd0,  4'd15, 3'd1, 1'b1, 8'h10, 1'b1};
    vecs[7] = '{1'b1, 4'd2,  4'd2,  3'd1, 1'b0, 4'd0,  4'd0,  3'd0, 1'b0, 8'h23, 1'b0};

    do_reset();
    chk("rst_rsp_valid", 32'(rsp_v), 32'd0);
    chk("rst_rsp_data", 32'(rsp_d), 32'd0);
    chk("rst_rsp_sign", 32'(rsp_s), 32'd0);
    chk("rst_rsp_id", 32'(rsp_i), 32'd0);
    chk("rst_calc", 32'({c_a, c_b, c_op}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_count", 32'(opc), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);
    chk("op_count_table", 32'(opc), 32'd8);

    // Both requesters held valid continuously: strict alternation starting with 0.
    do_reset();
    @(negedge clk);
    r0_v = 1'b1; r0_a = 4'd1; r0_b = 4'd1; r0_op = 3'd0;
    r1_v = 1'b1; r1_a = 4'd2; r1_b = 4'd2; r1_op = 3'd0;
    rsp_rdy = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (rsp_v) begin
        ids[got] = 32'(rsp_i);
        got++;
      end
    end
    r0_v = 1'b0; r1_v = 1'b0;
    chk("rr_count", 32'(got), 32'd4);
    for (int k = 0; k < 4; k++) chk("rr_id", 32'(ids[k]), 32'(k % 2));
    @(negedge clk);
    rsp_rdy = 1'b0;
    chk("rr_op_count", 32'(opc), 32'd4);

    // Stalled consumer with requester 1 waiting.
    @(negedge clk);
    r0_v = 1'b1; r0_a = 4'd4; r0_b = 4'd6; r0_op = 3'd1;
    r1_v = 1'b1; r1_a = 4'd9; r1_b = 4'd1; r1_op = 3'd2;
    @(negedge clk);
    r0_v = 1'b0;
    lat = 1;
    while (!rsp_v && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_data", 32'(rsp_d), 32'h47);
    chk("stall_sign", 32'(rsp_s), 32'd1);
    held = rsp_d;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!rsp_v || rsp_d !== held || rsp_i !== 1'b0 || r1_rdy !== 1'b0 || busy !== 1'b1)
        stable = 1'b0;
    end
    chk("stall_hold", 32'(stable), 32'd1);
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    chk("stall_release_ready1", 32'(r1_rdy), 32'd1);
    @(negedge clk);
    r1_v = 1'b0;
    lat = 1;
    while (!rsp_v && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_next_id", 32'(rsp_i), 32'd1);
    chk("stall_next_data", 32'(rsp_d), 32'h93);
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    chk("stall_op_count", 32'(opc), 32'd6);

    // Reset while an op is executing drops it.
    @(negedge clk);
    r0_v = 1'b1; r0_a = 4'd7; r0_b = 4'd3; r0_op = 3'd1;
    @(negedge clk);
    r0_v = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(rsp_v), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_calc", 32'({c_a, c_b, c_op}), 32'd0);
    chk("mid_rst_op_count", 32'(opc), 32'd0);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_v !== 1'b0) stable = 1'b0;
    end
    chk("mid_rst_no_rsp", 32'(stable), 32'd1);

    // SETTLE=3, CNTW=2 build: longer latency, stable operands, counter wrap.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ea = 4'(k); eb = 4'(k + 5); eo = 3'(k);
      v2 = 1'b1; a2 = ea; b2 = eb; op2 = eo;
      #1;
      chk("s3_ready", 32'(rdy2), 32'd1);
      @(negedge clk);
      v2 = 1'b0;
      sa = c2_a; sb = c2_b; so = c2_op;
      chk("s3_calc", 32'({sa, sb, so}), 32'({ea, eb, eo}));
      stable = 1'b1;
      lat = 1;
      while (!rsp2_v && lat < 12) begin
        @(negedge clk);
        lat++;
        if (c2_a !== sa || c2_b !== sb || c2_op !== so) stable = 1'b0;
      end
      chk("s3_latency", 32'(lat), 32'd4);
      chk("s3_calc_stable", 32'(stable), 32'd1);
      chk("s3_data", 32'(rsp2_d), 32'(8'({ea, eb}) + 8'(eo)));
      chk("s3_sign", 32'(rsp2_s), 32'((eo == 3'd1) && (ea < eb)));
      rsp2_rdy = 1'b1;
      @(negedge clk);
      rsp2_rdy = 1'b0;
    end
    chk("s3_op_count_wrap", 32'(opc2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
